// File: rtl/param_toggle_counter.sv
// param_toggle_counter
//   WIDTH-bit synchronous up/down modulo counter. Each step is formed by
//   toggle logic rather than an adder. A bit flips when every lower bit is 1
//   (counting up) or every lower bit is 0 (counting down). The range limits
//   are handled explicitly, so q never leaves 0..MODULUS-1.
//
//   Compile-time option:
//     PTC_SATURATE_EN - when defined, the counter saturates at the range
//                       limits instead of wrapping. In that mode, wrap flags
//                       a step that was blocked at a limit.
//
//   Parameters:
//     WIDTH    - counter width in bits (>= 1)
//     MODULUS  - count range 0..MODULUS-1, legal 2..2**WIDTH
//
//   Ports:
//     clk      - rising-edge clock
//     rst      - asynchronous active-high reset (q=0, wrap=0)
//     en       - count enable, one step per clock
//     up       - direction: 1 = increment, 0 = decrement
//     clear    - synchronous clear to 0 (highest priority)
//     load     - synchronous parallel load, clamped to MODULUS-1
//     load_val - value for load
//     q        - current count
//     tc       - terminal count, combinational: en & (q at the limit for 'up')
//     wrap     - registered one-cycle pulse following a wrapping edge
module param_toggle_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             at_limit;

  // One step via toggle masks. Bit 0 always toggles. Higher bits toggle
  // when all lower bits are 1 (up) or all lower bits are 0 (down).
  function automatic logic [WIDTH-1:0] toggle_step(input logic [WIDTH-1:0] cur,
                                                   input logic             dir_up);
    logic [WIDTH-1:0] t;
    t    = '0;
    t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t[i] = t[i-1] & (dir_up ? cur[i-1] : ~cur[i-1]);
    end
    return cur ^ t;
  endfunction

  // Load values outside the count range are clamped to the top of the range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  always_comb begin
    at_limit = up ? (q == MAX_VAL) : (q == '0);
    tc       = en & at_limit;
  end

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (clear) begin
      q_nxt = '0;
    end else if (load) begin
      q_nxt = clamp_load(load_val);
    end else if (en) begin
      if (at_limit) begin
`ifdef PTC_SATURATE_EN
        q_nxt    = q;
`else
        q_nxt    = up ? '0 : MAX_VAL;
`endif
        wrap_nxt = 1'b1;
      end else begin
        q_nxt = toggle_step(q, up);
      end
    end
  end

  // State register: count and wrap pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: doc/param_toggle_counter.md
Name: param_toggle_counter

Overview:
Parametrised successor to the single-bit toggle flip-flop: a WIDTH-bit synchronous up/down modulo counter whose bits advance by toggle logic.
- Adds count enable, direction, parallel load, synchronous clear, programmable modulus, terminal-count and wrap indications.
- Used as the general counter/divider primitive in later labs: clock dividers, BCD digits, FSM timers.

Parameters:
WIDTH, 4, counter width in bits (>=1)
MODULUS, 16, count range 0..MODULUS-1; legal 2..2**WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
en  input  1  count enable; one step per clock when high
up  input  1  direction: 1 = increment, 0 = decrement
clear  input  1  synchronous clear to 0
load  input  1  synchronous parallel load
load_val  input  WIDTH  value for load
q  output  WIDTH  current count
tc  output  1  terminal count (combinational)
wrap  output  1  one-cycle registered pulse after a wrap

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high: q=0, wrap=0 immediately on rst rising, independent of clk, held while rst=1.
- Reset value of tc follows its combinational definition (q=0).
- First counting edge is the first rising clk with rst=0.
- Per-edge priority when rst=0: clear > load > en > hold.
- clear=1: q<=0, wrap<=0; load and en ignored.
- load=1 (clear=0): q<=load_val if load_val<=MODULUS-1, else q<=MODULUS-1 (clamp). wrap<=0. en ignored.
- en=1, up=1: q<=q+1. If q==MODULUS-1: q<=0 and wrap<=1.
- en=1, up=0: q<=q-1. If q==0: q<=MODULUS-1 and wrap<=1.
- en=0: q holds, wrap<=0.
- wrap is high for exactly the one cycle following the wrapping edge. Consecutive wraps (MODULUS=2, en held) give wrap high on consecutive cycles.
- tc = en & (up ? q==MODULUS-1 : q==0), combinational. It asserts in the cycle before the wrap edge and is intended for cascading into the next stage's en.
- Direction may change on any cycle; the step uses the up value sampled at that edge.
- Arithmetic uses WIDTH bits. q never leaves 0..MODULUS-1, including after load, so no out-of-range state is reachable.
- Latency: q reflects a count/load/clear one clock after the edge; tc has zero latency; wrap has one cycle.
- rst asserted mid-count: q=0 immediately; a pending wrap pulse is cancelled.

Optional Feature:
Macro PTC_SATURATE_EN.
- Defined: counter saturates instead of wrapping.
  - up at MODULUS-1 holds MODULUS-1.
  - down at 0 holds 0.
  - wrap pulses one cycle when a step is blocked at the limit; it stays high every cycle while en is held at the limit.
  - tc is unchanged.
- Undefined: modulo wrap behaviour as above.

Test Plan:
- WIDTH=4, MODULUS=10. rst=1 mid-count at q=7, asynchronously between edges -> q=0 and wrap=0 before the next edge. Hold rst 2 cycles -> q stays 0.
- en=1, up=1 from q=0 for 12 edges -> q=1..9,0,1,2. tc=1 only while q=9. wrap=1 only in the cycle with q=0 following 9.
- en=1, up=0 from q=0 -> q=9 after one edge with wrap=1. tc=1 while q=0 in the preceding cycle.
- load=1, load_val=4'd13 -> q=9 (clamp). Then load=1, load_val=5 with en=1 -> q=5, no count.
- clear=1 and load=1 and en=1 together at q=6 -> q=0, wrap=0.
- With PTC_SATURATE_EN, en=1, up=1 from q=8 for 3 edges -> q=9,9,9. wrap=1 on the 2nd and 3rd cycles. Without the macro -> q=9,0,1.
